// File: rtl/sparc_ifu_thrsched.sv
// Four-thread IFU fetch scheduler: per-thread state tracking, round-robin
// pick of the next fetch thread and sticky wait-timeout flags.
//
// state   | meaning
// --------+-------------------------------------------------------------
// ST_OFF  | thread not enabled
// ST_RDY  | runnable, candidate for the next pick
// ST_RUN  | owns the fetch slot (at most one thread at a time)
// ST_WAIT | waiting for a completion pulse; timeout counter running
module sparc_ifu_thrsched #(
   parameter int TMO_W   = 8,
   parameter int TMO_MAX = 200
) (
   input  logic       clk,
   input  logic       arst_l,
   input  logic [3:0] thr_active,
   input  logic [3:0] completion,
   input  logic [3:0] wait_set,
   input  logic       switch_req,
   input  logic       stall,
   output logic [3:0] thr_f,
   output logic [3:0] thr_rdy,
   output logic [3:0] thr_wait,
   output logic       sw_vld,
   output logic [3:0] wait_tmo
);

   typedef enum logic [1:0] {
      ST_OFF  = 2'd0,
      ST_RDY  = 2'd1,
      ST_RUN  = 2'd2,
      ST_WAIT = 2'd3
   } thr_st_e;

   localparam logic [TMO_W-1:0] CNT_SAT = '1;
   localparam logic [TMO_W-1:0] CNT_ONE = {{(TMO_W-1){1'b0}}, 1'b1};
   localparam logic [TMO_W-1:0] CNT_TMO = TMO_W'(TMO_MAX);

   thr_st_e          r_state [4];
   logic [TMO_W-1:0] r_cnt   [4];
   logic [3:0]       r_tmo;
   logic [3:0]       r_thr_f;
   logic [3:0]       r_thr_rdy;
   logic [3:0]       r_thr_wait;
   logic             r_sw_vld;
   logic [1:0]       r_ptr;

   thr_st_e          w_state_nxt [4];
   logic [TMO_W-1:0] w_cnt_nxt   [4];
   logic [3:0]       w_tmo_nxt;
   logic [3:0]       w_rdy;
   logic [3:0]       w_run;
   logic [3:0]       w_cand;
   logic [3:0]       w_pick_oh;
   logic [3:0]       w_f_nxt;
   logic [3:0]       w_rdy_nxt;
   logic [3:0]       w_wait_nxt;
   logic             w_switch;
   logic             w_slot_free;
   logic             w_pick;
   logic             w_found;
   logic [1:0]       w_pick_idx;
   logic [1:0]       w_rr_idx;

   // decode the registered per-thread state into RDY / RUN masks
   always_comb begin
      w_rdy = 4'b0000;
      w_run = 4'b0000;
      for (int i = 0; i < 4; i++) begin
         w_rdy[i] = (r_state[i] == ST_RDY);
         w_run[i] = (r_state[i] == ST_RUN);
      end
   end

   // a thread being deactivated this cycle cannot be picked, it goes OFF
   assign w_cand      = w_rdy & thr_active;
   assign w_switch    = switch_req & ~stall & (|w_run) & (|w_cand);
   assign w_slot_free = ~(|w_run) | (|(w_run & (wait_set | ~thr_active))) | w_switch;
   assign w_pick      = ~stall & w_slot_free & (|w_cand);

   // round-robin search starting after the last picked thread
   always_comb begin
      w_found    = 1'b0;
      w_pick_idx = r_ptr;
      w_rr_idx   = r_ptr;
      for (int k = 1; k <= 4; k++) begin
         w_rr_idx = r_ptr + 2'(k);
         if (!w_found && w_cand[w_rr_idx]) begin
            w_found    = 1'b1;
            w_pick_idx = w_rr_idx;
         end
      end
   end

   assign w_pick_oh = w_pick ? (4'b0001 << w_pick_idx) : 4'b0000;

   // per-thread next-state logic, deactivation has top priority
   always_comb begin
      for (int i = 0; i < 4; i++) begin
         w_state_nxt[i] = r_state[i];
         if (!thr_active[i]) begin
            w_state_nxt[i] = ST_OFF;
         end else begin
            case (r_state[i])
               ST_OFF:  w_state_nxt[i] = ST_RDY;
               ST_RDY:  if (w_pick_oh[i]) w_state_nxt[i] = ST_RUN;
               ST_RUN: begin
                  if (wait_set[i] && completion[i]) w_state_nxt[i] = ST_RDY;
                  else if (wait_set[i])             w_state_nxt[i] = ST_WAIT;
                  else if (w_switch)                w_state_nxt[i] = ST_RDY;
               end
               ST_WAIT: if (completion[i]) w_state_nxt[i] = ST_RDY;
               default: w_state_nxt[i] = ST_OFF;
            endcase
         end
      end
   end

   // wait counters: zero outside WAIT, so entry always starts from zero;
   // the flag tracks the next count so it appears TMO_MAX+1 cycles after wait_set
   always_comb begin
      w_tmo_nxt = 4'b0000;
      for (int i = 0; i < 4; i++) begin
         w_cnt_nxt[i] = '0;
         if (r_state[i] == ST_WAIT && w_state_nxt[i] == ST_WAIT) begin
            w_cnt_nxt[i] = (r_cnt[i] == CNT_SAT) ? r_cnt[i] : r_cnt[i] + CNT_ONE;
            w_tmo_nxt[i] = r_tmo[i] | (w_cnt_nxt[i] == CNT_TMO);
         end
      end
   end

   // next-cycle output vectors, registered below
   always_comb begin
      w_f_nxt    = 4'b0000;
      w_rdy_nxt  = 4'b0000;
      w_wait_nxt = 4'b0000;
      for (int i = 0; i < 4; i++) begin
         w_f_nxt[i]    = (w_state_nxt[i] == ST_RUN);
         w_rdy_nxt[i]  = (w_state_nxt[i] == ST_RDY);
         w_wait_nxt[i] = (w_state_nxt[i] == ST_WAIT);
      end
   end

   // FSM state register and round-robin pointer
   always_ff @(posedge clk or negedge arst_l) begin
      if (!arst_l) begin
         for (int i = 0; i < 4; i++) r_state[i] <= ST_OFF;
         r_ptr <= 2'd3;
      end else begin
         for (int i = 0; i < 4; i++) r_state[i] <= w_state_nxt[i];
         if (w_pick) r_ptr <= w_pick_idx;
      end
   end

   // timeout counters and registered outputs
   always_ff @(posedge clk or negedge arst_l) begin
      if (!arst_l) begin
         for (int i = 0; i < 4; i++) r_cnt[i] <= '0;
         r_tmo      <= 4'b0000;
         r_thr_f    <= 4'b0000;
         r_thr_rdy  <= 4'b0000;
         r_thr_wait <= 4'b0000;
         r_sw_vld   <= 1'b0;
      end else begin
         for (int i = 0; i < 4; i++) r_cnt[i] <= w_cnt_nxt[i];
         r_tmo      <= w_tmo_nxt;
         r_thr_f    <= w_f_nxt;
         r_thr_rdy  <= w_rdy_nxt;
         r_thr_wait <= w_wait_nxt;
         r_sw_vld   <= w_pick;
      end
   end

   assign thr_f    = r_thr_f;
   assign thr_rdy  = r_thr_rdy;
   assign thr_wait = r_thr_wait;
   assign sw_vld   = r_sw_vld;
   assign wait_tmo = r_tmo;

endmodule
